sdram_arbiter: RTL and testbench

Shares the single Avalon-MM SDRAM master port among `COUNT` GPU cores. Each core presents its own read/write request and sees its own waitrequest/readdatavalid. The arbiter grants one core at a time in round-robin order and holds that grant until the transaction completes: write accepted, or read data returned. It also applies the fixed byte-offset and byte-to-word address translation for the shared port. Sits between the GPU core array and the top-level SDRAM port, replacing wire-OR muxing of core SDRAM outputs.

---
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one Avalon-MM SDRAM master port among COUNT cores.
// One grant at a time, chosen round-robin, held until the transaction
// completes (write accepted, or read data returned). Core byte addresses are
// offset by BASE_BYTE and converted to SDRAM word addresses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no owner; pick the next requester after last_grant
// S_ISSUE     | owner's command driven on the SDRAM port until accepted
// S_WAIT_DATA | read accepted; waiting for the single returning data beat
module sdram_arbiter #(
    parameter int          COUNT         = 4,
    parameter int          WORD_WIDTH    = 32,
    parameter int          ADDRESS_WIDTH = 24,
    parameter logic [29:0] BASE_BYTE     = 30'h3E000000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [COUNT*ADDRESS_WIDTH-1:0]  core_address,
    input  logic [COUNT-1:0]                core_read,
    input  logic [COUNT-1:0]                core_write,
    input  logic [COUNT*WORD_WIDTH-1:0]     core_writedata,
    output logic [COUNT-1:0]                core_waitrequest,
    output logic [COUNT-1:0]                core_readdatavalid,
    output logic [WORD_WIDTH-1:0]           core_readdata,
    output logic [29:0]                     sdram_address,
    output logic                            sdram_read,
    output logic                            sdram_write,
    output logic [WORD_WIDTH-1:0]           sdram_writedata,
    input  logic                            sdram_waitrequest,
    input  logic [WORD_WIDTH-1:0]           sdram_readdata,
    input  logic                            sdram_readdatavalid,
    output logic [COUNT-1:0]                grant,
    output logic                            busy
);

    localparam int LG = (COUNT > 1) ? $clog2(COUNT) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;

    logic [1:0]               state;
    logic [LG-1:0]            owner;
    logic [LG-1:0]            last_grant;
    logic [COUNT-1:0]         req;
    logic [LG-1:0]            pick;
    logic [LG-1:0]            cand;
    logic                     found;
    logic                     own_read;
    logic                     own_write;
    logic                     own_req;
    logic [ADDRESS_WIDTH-1:0] own_address;
    logic [WORD_WIDTH-1:0]    own_writedata;
    logic [29:0]              byte_address;
    logic                     issuing;

    function automatic logic [LG-1:0] rr_next(input logic [LG-1:0] from);
        return (from == LG'(COUNT - 1)) ? '0 : from + LG'(1);
    endfunction

    // A core asserting both read and write counts as one request (a read).
    assign req = core_read | core_write;

    // Round-robin search: first requester strictly after last_grant, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = rr_next(last_grant);
        for (int k = 0; k < COUNT; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = rr_next(cand);
        end
    end

    assign own_read      = core_read[owner];
    assign own_write     = core_write[owner];
    assign own_req       = own_read | own_write;
    assign own_address   = core_address[owner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign own_writedata = core_writedata[owner*WORD_WIDTH +: WORD_WIDTH];
    assign issuing       = (state == S_ISSUE);

    // Offset wraps modulo 2^30 before dropping the byte lane bits.
    assign byte_address    = 30'(own_address) + BASE_BYTE;
    assign sdram_address   = issuing ? (byte_address >> 2) : '0;
    assign sdram_read      = issuing & own_read;
    assign sdram_write     = issuing & own_write & ~own_read;
    assign sdram_writedata = issuing ? own_writedata : '0;
    assign core_readdata   = sdram_readdata;
    assign busy            = (state != S_IDLE);

    // Only the owner in ISSUE sees the SDRAM stall; everyone else is held off.
    always_comb begin
        core_waitrequest = '1;
        if (issuing) begin
            core_waitrequest[owner] = sdram_waitrequest;
        end
    end

    // Read data is steered to the owner only while a read is outstanding.
    always_comb begin
        core_readdatavalid = '0;
        if (state == S_WAIT_DATA && sdram_readdatavalid) begin
            core_readdatavalid[owner] = 1'b1;
        end
    end

    // Grant/ownership state machine.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_grant <= LG'(COUNT - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= pick;
                        grant <= COUNT'(1) << pick;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!own_req) begin
                        // Owner withdrew before acceptance: nothing was issued.
                        last_grant <= owner;
                        grant      <= '0;
                        state      <= S_IDLE;
                    end else if (!sdram_waitrequest) begin
                        if (own_read) begin
                            state <= S_WAIT_DATA;
                        end else begin
                            last_grant <= owner;
                            grant      <= '0;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (sdram_readdatavalid) begin
                        last_grant <= owner;
                        grant      <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_sdram_arbiter;

    localparam int          COUNT = 4;
    localparam int          WW    = 32;
    localparam int          AW    = 24;
    localparam logic [29:0] BASE  = 30'h3E000000;

    logic                   clock;
    logic                   reset_n;
    logic [COUNT*AW-1:0]    core_address;
    logic [COUNT-1:0]       core_read;
    logic [COUNT-1:0]       core_write;
    logic [COUNT*WW-1:0]    core_writedata;
    logic [COUNT-1:0]       core_waitrequest;
    logic [COUNT-1:0]       core_readdatavalid;
    logic [WW-1:0]          core_readdata;
    logic [29:0]            sdram_address;
    logic                   sdram_read;
    logic                   sdram_write;
    logic [WW-1:0]          sdram_writedata;
    logic                   sdram_waitrequest;
    logic [WW-1:0]          sdram_readdata;
    logic                   sdram_readdatavalid;
    logic [COUNT-1:0]       grant;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter #(
        .COUNT(COUNT), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .BASE_BYTE(BASE)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .core_address(core_address),
        .core_read(core_read),
        .core_write(core_write),
        .core_writedata(core_writedata),
        .core_waitrequest(core_waitrequest),
        .core_readdatavalid(core_readdatavalid),
        .core_readdata(core_readdata),
        .sdram_address(sdram_address),
        .sdram_read(sdram_read),
        .sdram_write(sdram_write),
        .sdram_writedata(sdram_writedata),
        .sdram_waitrequest(sdram_waitrequest),
        .sdram_readdata(sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .grant(grant),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          core;
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [31:0] wdata;
        int          stall;
        int          lat;
        logic [31:0] rdata;
        logic [29:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    // reference model state for the random phase
    int          m_owner;
    bit          m_wait;
    int          m_last;
    int          rd_cnt;
    bit          pend[COUNT];
    int          pkind[COUNT];
    logic [23:0] paddr[COUNT];
    logic [31:0] pdata[COUNT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic set_core(input int c, input logic rd, input logic wr,
                            input logic [23:0] a, input logic [31:0] d);
        core_read[c]             = rd;
        core_write[c]            = wr;
        core_address[c*AW +: AW] = a;
        core_writedata[c*WW +: WW] = d;
    endtask

    task automatic quiet_inputs();
        core_read           = '0;
        core_write          = '0;
        sdram_waitrequest   = 1'b0;
        sdram_readdatavalid = 1'b0;
        sdram_readdata      = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        quiet_inputs();
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    function automatic logic [29:0] xlate(input logic [23:0] a);
        longint unsigned s;
        s = 64'(a) + 64'(BASE);
        s = s % 64'h40000000;
        return 30'(s / 4);
    endfunction

    // One complete single-requester transaction from an idle arbiter.
    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0] oh;
        oh = 4'(1) << v.core;
        set_core(v.core, v.rd, v.wr, v.addr, v.wdata);
        sdram_waitrequest = (v.stall > 0);
        to_sample();
        check($sformatf("v%0d idle busy", idx), busy, 0);
        check($sformatf("v%0d idle grant", idx), grant, 0);
        check($sformatf("v%0d idle waitreq", idx), core_waitrequest, 4'hF);
        check($sformatf("v%0d idle cmd", idx), {sdram_read, sdram_write}, 0);
        next_cycle();
        for (int s = 0; s <= v.stall; s++) begin
            sdram_waitrequest = (s < v.stall);
            to_sample();
            check($sformatf("v%0d grant", idx), grant, oh);
            check($sformatf("v%0d address", idx), sdram_address, v.exp_addr);
            check($sformatf("v%0d read", idx), sdram_read, v.rd);
            check($sformatf("v%0d write", idx), sdram_write, !v.rd);
            check($sformatf("v%0d writedata", idx), sdram_writedata, v.wdata);
            check($sformatf("v%0d waitreq", idx), core_waitrequest,
                  (s < v.stall) ? 4'hF : (4'hF & ~oh));
            next_cycle();
        end
        set_core(v.core, 1'b0, 1'b0, v.addr, v.wdata);
        sdram_waitrequest = 1'b0;
        if (v.rd) begin
            for (int l = 1; l <= v.lat; l++) begin
                if (l == v.lat) begin
                    sdram_readdatavalid = 1'b1;
                    sdram_readdata      = v.rdata;
                end
                to_sample();
                check($sformatf("v%0d wait busy", idx), busy, 1);
                check($sformatf("v%0d wait cmd", idx), {sdram_read, sdram_write}, 0);
                check($sformatf("v%0d wait address", idx), sdram_address, 0);
                check($sformatf("v%0d rdvalid", idx), core_readdatavalid,
                      (l == v.lat) ? oh : 4'h0);
                if (l == v.lat) check($sformatf("v%0d readdata", idx), core_readdata, v.rdata);
                next_cycle();
                sdram_readdatavalid = 1'b0;
            end
        end
        to_sample();
        check($sformatf("v%0d done busy", idx), busy, 0);
        check($sformatf("v%0d done grant", idx), grant, 0);
        check($sformatf("v%0d done cmd", idx), {sdram_read, sdram_write}, 0);
        next_cycle();
    endtask

    initial begin
        int rdv_count;
        bit saw_core3;
        logic [3:0] exp_wr;
        logic [3:0] exp_rdv;
        bit issuing;
        int o;

        vecs[0] = '{2, 1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 0, 0, 32'h0,         30'h0F800004};
        vecs[1] = '{0, 1'b0, 1'b1, 24'hFFFFFC, 32'hCAFEF00D, 0, 0, 32'h0,         30'h0FBFFFFF};
        vecs[2] = '{1, 1'b1, 1'b0, 24'h000000, 32'h11111111, 3, 5, 32'h12345678,  30'h0F800000};
        vecs[3] = '{3, 1'b1, 1'b0, 24'h123456, 32'h22222222, 1, 1, 32'hA5A55A5A,  30'h0F848D15};
        vecs[4] = '{1, 1'b0, 1'b1, 24'h000003, 32'h00000001, 2, 0, 32'h0,         30'h0F800000};
        vecs[5] = '{0, 1'b1, 1'b0, 24'hABCDEF, 32'h33333333, 0, 2, 32'hFEEDFACE,  30'h0FAAF37B};
        vecs[6] = '{2, 1'b1, 1'b1, 24'h000100, 32'h55AA55AA, 0, 3, 32'h0BADF00D,  30'h0F800040};

        reset_n        = 1'b0;
        core_address   = '0;
        core_writedata = '0;
        quiet_inputs();
        next_cycle();
        next_cycle();
        to_sample();
        check("reset busy", busy, 0);
        check("reset grant", grant, 0);
        check("reset cmd", {sdram_read, sdram_write}, 0);
        check("reset waitreq", core_waitrequest, 4'hF);
        check("reset rdvalid", core_readdatavalid, 0);
        check("reset address", sdram_address, 0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // fairness: all cores write continuously, starting from reset
        do_reset();
        for (int c = 0; c < COUNT; c++) set_core(c, 1'b0, 1'b1, 24'(c * 4), 32'hC0DE0000 + 32'(c));
        for (int cyc = 0; cyc < 10; cyc++) begin
            to_sample();
            if (cyc % 2 == 0) begin
                check($sformatf("fair c%0d grant", cyc), grant, 0);
                check($sformatf("fair c%0d write", cyc), sdram_write, 0);
            end else begin
                check($sformatf("fair c%0d grant", cyc), grant, 4'(1) << (((cyc - 1) / 2) % 4));
                check($sformatf("fair c%0d write", cyc), sdram_write, 1);
                check($sformatf("fair c%0d address", cyc), sdram_address,
                      30'h0F800000 + 30'(((cyc - 1) / 2) % 4));
                check($sformatf("fair c%0d wdata", cyc), sdram_writedata,
                      32'hC0DE0000 + 32'(((cyc - 1) / 2) % 4));
            end
            next_cycle();
        end
        quiet_inputs();
        next_cycle();

        // stalled read on core 1 while core 3 waits (last owner was core 0)
        set_core(1, 1'b1, 1'b0, 24'h000040, 32'h0);
        set_core(3, 1'b0, 1'b1, 24'h000080, 32'h99990003);
        sdram_waitrequest = 1'b1;
        rdv_count = 0;
        saw_core3 = 0;
        to_sample();
        check("stall idle grant", grant, 0);
        next_cycle();
        for (int s = 0; s < 4; s++) begin
            sdram_waitrequest = (s < 3);
            to_sample();
            check($sformatf("stall s%0d grant", s), grant, 4'b0010);
            check($sformatf("stall s%0d read", s), sdram_read, 1);
            check($sformatf("stall s%0d waitreq", s), core_waitrequest, (s < 3) ? 4'hF : 4'hD);
            next_cycle();
        end
        set_core(1, 1'b0, 1'b0, 24'h000040, 32'h0);
        sdram_waitrequest = 1'b0;
        for (int l = 1; l <= 5; l++) begin
            if (l == 5) begin
                sdram_readdatavalid = 1'b1;
                sdram_readdata      = 32'h12345678;
            end
            to_sample();
            if (core_readdatavalid[1]) rdv_count++;
            if (grant[3]) saw_core3 = 1;
            if (l == 5) check("stall readdata", core_readdata, 32'h12345678);
            next_cycle();
            sdram_readdatavalid = 1'b0;
        end
        check("stall rdvalid pulses", rdv_count, 1);
        check("stall core3 early", saw_core3, 0);
        to_sample();
        check("stall after grant", grant, 0);
        next_cycle();
        to_sample();
        check("core3 grant", grant, 4'b1000);
        check("core3 write", sdram_write, 1);
        check("core3 address", sdram_address, 30'h0F800020);
        next_cycle();
        quiet_inputs();
        next_cycle();

        // reset while a read is outstanding
        set_core(0, 1'b1, 1'b0, 24'h000000, 32'h0);
        next_cycle();
        next_cycle();
        set_core(0, 1'b0, 1'b0, 24'h000000, 32'h0);
        to_sample();
        check("rst wait busy", busy, 1);
        check("rst wait grant", grant, 4'b0001);
        next_cycle();
        reset_n = 1'b0;
        #1;
        check("rst async busy", busy, 0);
        check("rst async grant", grant, 0);
        check("rst async waitreq", core_waitrequest, 4'hF);
        check("rst async cmd", {sdram_read, sdram_write}, 0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 32'hBAD0BAD0;
        to_sample();
        check("rst late rdvalid", core_readdatavalid, 0);
        check("rst late busy", busy, 0);
        next_cycle();
        sdram_readdatavalid = 1'b0;
        set_core(0, 1'b0, 1'b1, 24'h000000, 32'h1);
        set_core(2, 1'b0, 1'b1, 24'h000000, 32'h2);
        next_cycle();
        to_sample();
        check("rst first grant", grant, 4'b0001);
        next_cycle();
        set_core(0, 1'b0, 1'b0, 24'h000000, 32'h1);
        next_cycle();
        to_sample();
        check("rst second grant", grant, 4'b0100);
        next_cycle();
        quiet_inputs();
        next_cycle();

        // stray data in IDLE and ISSUE, then withdrawal by the owner
        sdram_readdatavalid = 1'b1;
        to_sample();
        check("stray idle rdvalid", core_readdatavalid, 0);
        next_cycle();
        sdram_readdatavalid = 1'b0;
        to_sample();
        check("stray idle busy", busy, 0);
        set_core(2, 1'b1, 1'b0, 24'h000000, 32'h0);
        sdram_waitrequest = 1'b1;
        next_cycle();
        sdram_readdatavalid = 1'b1;
        to_sample();
        check("stray issue rdvalid", core_readdatavalid, 0);
        check("stray issue read", sdram_read, 1);
        next_cycle();
        sdram_readdatavalid = 1'b0;
        set_core(2, 1'b0, 1'b0, 24'h000000, 32'h0);
        set_core(0, 1'b0, 1'b1, 24'h000004, 32'hA0);
        set_core(3, 1'b0, 1'b1, 24'h00000C, 32'hA3);
        to_sample();
        check("withdraw cmd", {sdram_read, sdram_write}, 0);
        check("withdraw grant", grant, 4'b0100);
        next_cycle();
        sdram_waitrequest = 1'b0;
        to_sample();
        check("withdraw idle busy", busy, 0);
        next_cycle();
        to_sample();
        check("withdraw next grant", grant, 4'b1000);
        check("withdraw next write", sdram_write, 1);
        next_cycle();
        set_core(3, 1'b0, 1'b0, 24'h00000C, 32'hA3);
        next_cycle();
        to_sample();
        check("withdraw then core0", grant, 4'b0001);
        next_cycle();
        quiet_inputs();
        next_cycle();

        // randomized traffic against the transaction-level model
        do_reset();
        m_owner = -1;
        m_wait  = 0;
        m_last  = COUNT - 1;
        rd_cnt  = 0;
        for (int c = 0; c < COUNT; c++) pend[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < COUNT; c++) begin
                if (!pend[c] && $urandom_range(0, 3) == 0) begin
                    pend[c]  = 1;
                    pkind[c] = $urandom_range(0, 2);
                    paddr[c] = 24'($urandom);
                    pdata[c] = $urandom;
                end
                if (pend[c]) set_core(c, pkind[c] != 1, pkind[c] != 0, paddr[c], pdata[c]);
                else         set_core(c, 1'b0, 1'b0, 24'($urandom), $urandom);
            end
            sdram_waitrequest = ($urandom_range(0, 2) == 0);
            sdram_readdata    = $urandom;
            if (m_owner >= 0 && m_wait) begin
                rd_cnt--;
                sdram_readdatavalid = (rd_cnt == 0);
            end else begin
                sdram_readdatavalid = ($urandom_range(0, 7) == 0);
            end
            to_sample();
            o       = (m_owner >= 0) ? m_owner : 0;
            issuing = (m_owner >= 0) && !m_wait;
            exp_wr  = 4'hF;
            if (issuing) exp_wr[o] = sdram_waitrequest;
            exp_rdv = (m_owner >= 0 && m_wait && sdram_readdatavalid) ? 4'(1) << o : 4'h0;
            check("rnd grant", grant, (m_owner >= 0) ? 4'(1) << o : 4'h0);
            check("rnd busy", busy, m_owner >= 0);
            check("rnd read", sdram_read, issuing && pkind[o] != 1);
            check("rnd write", sdram_write, issuing && pkind[o] == 1);
            check("rnd address", sdram_address, issuing ? xlate(paddr[o]) : 30'h0);
            check("rnd writedata", sdram_writedata, issuing ? pdata[o] : 32'h0);
            check("rnd waitreq", core_waitrequest, exp_wr);
            check("rnd rdvalid", core_readdatavalid, exp_rdv);
            check("rnd readdata", core_readdata, sdram_readdata);
            if (m_owner < 0) begin
                for (int k = 1; k <= COUNT; k++) begin
                    if (m_owner < 0 && pend[(m_last + k) % COUNT]) m_owner = (m_last + k) % COUNT;
                end
                m_wait = 0;
            end else if (!m_wait) begin
                if (!sdram_waitrequest) begin
                    pend[o] = 0;
                    if (pkind[o] != 1) begin
                        m_wait = 1;
                        rd_cnt = $urandom_range(1, 4);
                    end else begin
                        m_last  = o;
                        m_owner = -1;
                    end
                end
            end else if (sdram_readdatavalid) begin
                m_last  = o;
                m_owner = -1;
                m_wait  = 0;
            end
            next_cycle();
        end
        quiet_inputs();
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
